// File: rtl/count_history.sv
// Free-running event counter with a circular history of pre-edge count values.
// History entries are individually reset/cleared registers so unwritten slots read 0.

module count_history_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module count_history #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] TERMINAL  = {WIDTH{1'b1}},
  parameter bit               STOP_MODE = 1'b0,
  localparam int              AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             freeze,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] count,
  output logic [AW-1:0]    wr_ptr,
  output logic             hist_full,
  output logic             count_end,
  output logic             done
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               rd_idx;
  logic                        wr_en;
  logic                        at_term;
  logic                        done_q;

  assign wr_en   = en & ~freeze & ~clr;
  assign at_term = (count == TERMINAL);
  // Age 0 is the slot just behind the write pointer.
  assign rd_idx  = wr_ptr - AW'(1) - rd_addr;
  assign done    = STOP_MODE ? done_q : 1'b0;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_entry
      count_history_entry #(.WIDTH(WIDTH)) u_entry (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .we    (wr_en && (wr_ptr == AW'(i))),
        .d     (count),
        .q     (mem_q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      wr_ptr    <= '0;
      hist_full <= 1'b0;
      count_end <= 1'b0;
      done_q    <= 1'b0;
      rd_data   <= '0;
    end else if (clr) begin
      count     <= '0;
      wr_ptr    <= '0;
      hist_full <= 1'b0;
      count_end <= 1'b0;
      done_q    <= 1'b0;
      rd_data   <= '0;
    end else begin
      count_end <= 1'b0;
      rd_data   <= mem_q[rd_idx];
      if (en) begin
        if (!at_term) begin
          count <= count + WIDTH'(1);
        end else if (!STOP_MODE) begin
          count     <= '0;
          count_end <= 1'b1;
        end else if (!done_q) begin
          done_q    <= 1'b1;
          count_end <= 1'b1;
        end
        if (!freeze) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (wr_ptr == AW'(DEPTH-1)) hist_full <= 1'b1;
        end
      end
    end
  end
endmodule
